// File: rtl/relu_pkg.sv
// Shared definitions for the ReLU backward-pass block: FP32 field constants,
// FSM state encoding and the forward-activation mask rule.
package relu_pkg;

  localparam int          DATA_WIDTH_DEF = 32;
  localparam int          SIGN_BIT       = 31;
  localparam logic [31:0] POS_ZERO       = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECORD,
    ST_BACKWARD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Strictly positive: sign clear and not +0.0. Positive NaN and denormals count as positive.
  function automatic logic relu_mask(input logic [31:0] x);
    return ~x[SIGN_BIT] & (x[SIGN_BIT-1:0] != '0);
  endfunction

endpackage

// File: rtl/relu_mask_ram.sv
// DEPTH x 1-bit mask store: synchronous write, asynchronous read, no reset.
module relu_mask_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/relu_backward.sv
// ReLU backward pass: records a sign/zero mask from the forward stream, then
// gates the upstream gradient stream with it through a registered output stage.
module relu_backward
  import relu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 64,
  parameter int LEN_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      vec_len,
  input  logic                  fwd_valid,
  output logic                  fwd_ready,
  input  logic [DATA_WIDTH-1:0] fwd_data,
  input  logic                  grad_valid,
  output logic                  grad_ready,
  input  logic [DATA_WIDTH-1:0] grad_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic fwd_fire, grad_fire, out_fire, last_elem;
  logic mask_wr_bit, mask_rd_bit;

  assign fwd_fire    = fwd_valid & fwd_ready;
  assign grad_fire   = grad_valid & grad_ready;
  assign out_fire    = out_valid_q & out_ready;
  assign last_elem   = (cnt_q == (len_q - LEN_W'(1)));
  assign mask_wr_bit = relu_mask(fwd_data[SIGN_BIT:0]);

  relu_mask_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mask (
    .clk   (clk),
    .we    (fwd_fire),
    .waddr (cnt_q[AW-1:0]),
    .wdata (mask_wr_bit),
    .raddr (cnt_q[AW-1:0]),
    .rdata (mask_rd_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (start) state_d = (vec_len == '0) ? ST_DONE : ST_RECORD;
      ST_RECORD:   if (fwd_fire && last_elem) state_d = ST_BACKWARD;
      ST_BACKWARD: if (grad_fire && last_elem) state_d = ST_DRAIN;
      ST_DRAIN:    if (out_fire) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Gradient acceptance depends on out_ready so a drained slot refills in the same cycle.
  always_comb begin
    fwd_ready  = 1'b0;
    grad_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_RECORD: begin
        fwd_ready = 1'b1;
        busy      = 1'b1;
      end
      ST_BACKWARD: begin
        grad_ready = ~out_valid_q | out_ready;
        busy       = 1'b1;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (state_q == ST_IDLE && start) begin
      len_d = (vec_len > DEPTH_L) ? DEPTH_L : vec_len;
      cnt_d = '0;
    end
    if (fwd_fire || grad_fire) cnt_d = last_elem ? '0 : cnt_q + LEN_W'(1);
    if (grad_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = mask_rd_bit ? grad_data : DATA_WIDTH'(POS_ZERO);
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_relu_backward.sv
// Randomized self-checking bench for relu_backward: a queue-based model of the
// mask/gradient streams is compared against the DUT on every falling edge.
module tb_relu_backward;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int LEN_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic             fwd_valid, fwd_ready;
  logic [DW-1:0]    fwd_data;
  logic             grad_valid, grad_ready;
  logic [DW-1:0]    grad_data;
  logic             out_valid, out_ready;
  logic [DW-1:0]    out_data;
  logic             busy, done;

  always #5 clk = ~clk;

  relu_backward #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .vec_len    (vec_len),
    .fwd_valid  (fwd_valid),
    .fwd_ready  (fwd_ready),
    .fwd_data   (fwd_data),
    .grad_valid (grad_valid),
    .grad_ready (grad_ready),
    .grad_data  (grad_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] expQ[$];
  logic [31:0] gotOut[$];
  bit          maskArr [128];
  logic [31:0] fwdVals [128];
  logic [31:0] gradVals[128];
  int fCount, gCount, outCount;
  int lastF, lastG, lastOut;
  int doneCount = 0;
  int passBase;
  bit prevDone;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // A gradient passes only where the forward input was strictly positive.
  function automatic bit positiveInput(input logic [31:0] x);
    return (x[31] == 1'b0) && (x[30:0] != 31'd0);
  endfunction

  function automatic logic [31:0] pickFwd();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h0000_0002;
      3:       return 32'hFFC0_0000;
      4:       return 32'h7FC0_0000;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      fCount   = 0;
      gCount   = 0;
      outCount = 0;
      prevDone = 1'b0;
    end else begin
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expQ.size() != 0});
      if (out_valid && expQ.size() != 0) checkOutput("out_data", out_data, expQ[0]);
      if (out_valid && !out_ready) checkOutput("grad_ready_stall", {31'd0, grad_ready}, 32'd0);
      if (out_valid && out_ready) begin
        gotOut.push_back(out_data);
        outCount++;
        if (expQ.size() != 0) void'(expQ.pop_front());
      end
      if (grad_valid && grad_ready) begin
        expQ.push_back((gCount < 128 && maskArr[gCount]) ? grad_data : 32'h0000_0000);
        gCount++;
      end
      if (fwd_valid && fwd_ready) begin
        if (fCount < 128) maskArr[fCount] = positiveInput(fwd_data);
        fCount++;
      end
      if (done) begin
        checkOutput("done_single_cycle", {31'd0, prevDone}, 32'd0);
        lastF    = fCount;
        lastG    = gCount;
        lastOut  = outCount;
        fCount   = 0;
        gCount   = 0;
        outCount = 0;
        doneCount++;
      end
      prevDone = done;
    end
  end

  // readyMode: 0 = out_ready always high, 1 = random, 2 = three-cycle stall mid-stream.
  task automatic applyStimulus(input int vlen, input int readyMode, input bit pokeStart);
    int n;
    int dBase;
    int idx;
    int idle;
    int cyc;
    int waited;
    n        = (vlen > DEPTH) ? DEPTH : vlen;
    dBase    = doneCount;
    passBase = gotOut.size();
    @(posedge clk); #1;
    start   = 1'b1;
    vec_len = vlen[LEN_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
    if (vlen > 0) checkOutput("busy_after_start", {31'd0, busy}, 32'd1);

    idx  = 0;
    idle = 0;
    while (vlen > 0 && idx < vlen && idle < 60) begin
      fwd_valid = ($urandom_range(0, 3) != 0);
      fwd_data  = fwdVals[idx % 128];
      @(negedge clk);
      if (fwd_valid && fwd_ready) begin idx++; idle = 0; end
      else idle++;
      @(posedge clk); #1;
    end
    fwd_valid = 1'b0;

    idx  = 0;
    idle = 0;
    cyc  = 0;
    while (vlen > 0 && idx < vlen && idle < 60) begin
      grad_valid = (readyMode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      grad_data  = gradVals[idx % 128];
      case (readyMode)
        1:       out_ready = $urandom_range(0, 1);
        2:       out_ready = !(cyc >= 2 && cyc <= 4);
        default: out_ready = 1'b1;
      endcase
      if (pokeStart && cyc == 0) begin
        start   = 1'b1;
        vec_len = 7'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (grad_valid && grad_ready) begin idx++; idle = 0; end
      else idle++;
      @(posedge clk); #1;
      cyc++;
    end
    grad_valid = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b1;

    waited = 0;
    for (int k = 0; k < 100; k++) begin
      if (doneCount != dBase) break;
      @(posedge clk);
      waited++;
    end
    #1;
    checkOutput("done_seen", {31'd0, doneCount != dBase}, 32'd1);
    if (vlen == 0) checkOutput("len0_done_latency", {31'd0, waited <= 2}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("done_pulse_count", doneCount - dBase, 32'd1);
    checkOutput("fwd_accepted", lastF, n);
    checkOutput("grad_accepted", lastG, n);
    checkOutput("outputs_total", lastOut, n);
    checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic resetMidPass();
    int accepted;
    @(posedge clk); #1;
    start   = 1'b1;
    vec_len = 7'd5;
    @(posedge clk); #1;
    start     = 1'b0;
    fwd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fwd_data = 32'h3F80_0000 + i;
      @(posedge clk); #1;
    end
    fwd_valid  = 1'b0;
    grad_valid = 1'b1;
    grad_data  = 32'h4040_0000;
    out_ready  = 1'b1;
    accepted   = 0;
    for (int k = 0; k < 40 && accepted < 2; k++) begin
      @(negedge clk);
      if (grad_ready) accepted++;
      @(posedge clk); #1;
    end
    checkOutput("grads_before_reset", accepted, 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_fwd_ready", {31'd0, fwd_ready}, 32'd0);
    checkOutput("rst_grad_ready", {31'd0, grad_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    grad_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    fwdVals[0]  = 32'h4120_0000;
    gradVals[0] = 32'hBF80_0000;
    applyStimulus(1, 0, 1'b0);
    checkOutput("post_reset_out", gotOut[passBase], 32'hBF80_0000);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    vec_len    = '0;
    fwd_valid  = 1'b0;
    fwd_data   = '0;
    grad_valid = 1'b0;
    grad_data  = '0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_fwd_ready", {31'd0, fwd_ready}, 32'd0);
    checkOutput("reset_grad_ready", {31'd0, grad_ready}, 32'd0);
    rst = 1'b0;

    fwdVals[0] = 32'hC126_6666;
    fwdVals[1] = 32'h40B3_3333;
    fwdVals[2] = 32'h0000_0002;
    for (int i = 0; i < 3; i++) gradVals[i] = 32'h3F80_0000;
    applyStimulus(3, 0, 1'b0);
    checkOutput("lit3_out0", gotOut[passBase],     32'h0000_0000);
    checkOutput("lit3_out1", gotOut[passBase + 1], 32'h3F80_0000);
    checkOutput("lit3_out2", gotOut[passBase + 2], 32'h3F80_0000);

    fwdVals[0]  = 32'h8000_0000;
    fwdVals[1]  = 32'h0000_0000;
    gradVals[0] = 32'h4000_0000;
    gradVals[1] = 32'h4000_0000;
    applyStimulus(2, 0, 1'b0);
    checkOutput("lit2_out0", gotOut[passBase],     32'h0000_0000);
    checkOutput("lit2_out1", gotOut[passBase + 1], 32'h0000_0000);

    for (int i = 0; i < 4; i++) begin
      fwdVals[i]  = 32'h3F00_0000 + i;
      gradVals[i] = 32'h4100_0000 + i;
    end
    applyStimulus(4, 2, 1'b0);
    for (int i = 0; i < 4; i++) checkOutput("stall_seq", gotOut[passBase + i], 32'h4100_0000 + i);

    for (int i = 0; i < 128; i++) begin
      fwdVals[i]  = pickFwd();
      gradVals[i] = $urandom;
    end
    applyStimulus(100, 1, 1'b0);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(6, 1, 1'b1);

    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 128; i++) begin
        fwdVals[i]  = pickFwd();
        gradVals[i] = $urandom;
      end
      applyStimulus($urandom_range(1, 70), $urandom_range(0, 1), 1'b0);
    end

    resetMidPass();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
